// File: rtl/seg7_capture.sv
// Seven-segment bus capture: debounces strobed digit patterns, decodes them to hex nibbles
// and assembles four accepted digits into a 16-bit word.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [1:0]  dig_sel,
  input  logic        seg_strobe,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        err_pulse,
  output logic [1:0]  err_digit
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StStabilize = 2'd1;
  localparam logic [1:0] StLocked    = 2'd2;

  localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);
  localparam logic [6:0] SegBlank  = 7'h7f;

  logic [1:0]  state_q, state_d;
  logic [8:0]  sample_q, sample_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] asm_q, asm_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_dig_q, err_dig_d;

  logic [8:0]  sample_in;
  logic [4:0]  dec;
  logic        commit;

  // Returns {valid, nibble}; valid is 0 for any pattern outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1a;
      7'h03:   r = 5'h1b;
      7'h46:   r = 5'h1c;
      7'h21:   r = 5'h1d;
      7'h06:   r = 5'h1e;
      7'h0e:   r = 5'h1f;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    asm_d     = asm_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_dig_d = err_dig_q;
    commit    = 1'b0;
    sample_in = {dig_sel, seg_in};
    dec       = decode(seg_in);

    if (seg_strobe && seg_in != SegBlank) begin
      if (state_q == StIdle || sample_in != sample_q) begin
        sample_d = sample_in;
        cnt_d    = 4'd1;
        if (StableCnt == 4'd1) begin
          commit  = 1'b1;
          state_d = StLocked;
        end else begin
          state_d = StStabilize;
        end
      end else if (state_q == StStabilize) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == StableCnt) begin
          commit  = 1'b1;
          state_d = StLocked;
        end
      end
      // Locked with an equal sample: counter stays saturated, nothing commits.
    end

    if (commit) begin
      if (dec[4]) begin
        asm_d[{dig_sel, 2'b00} +: 4] = dec[3:0];
        mask_d[dig_sel]              = 1'b1;
        if (&mask_d) begin
          word_d  = asm_d;
          valid_d = 1'b1;
          mask_d  = 4'd0;
        end
      end else begin
        mask_d[dig_sel] = 1'b0;
        err_d           = 1'b1;
        err_dig_d       = dig_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sample_q  <= 9'd0;
      cnt_q     <= 4'd0;
      mask_q    <= 4'd0;
      asm_q     <= 16'd0;
      word_q    <= 16'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_dig_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      asm_q     <= asm_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_dig_q <= err_dig_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign err_pulse  = err_q;
  assign err_digit  = err_dig_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: vector table, directed corner sequences and randomized traffic
// checked against a run-length reference model.
module tb_seg7_capture;

  localparam int StableN = 4;

  logic        clk = 1'b0;
  logic        reset, seg_strobe;
  logic [6:0]  seg_in;
  logic [1:0]  dig_sel;
  logic [15:0] word_out;
  logic        word_valid, err_pulse;
  logic [1:0]  err_digit;

  logic        reset2, strobe2;
  logic [6:0]  seg2;
  logic [1:0]  dig2;
  logic [15:0] word2;
  logic        valid2, err2;
  logic [1:0]  errdig2;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(StableN)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel), .seg_strobe(seg_strobe),
    .word_out(word_out), .word_valid(word_valid), .err_pulse(err_pulse), .err_digit(err_digit)
  );

  seg7_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset2), .seg_in(seg2), .dig_sel(dig2), .seg_strobe(strobe2),
    .word_out(word2), .word_valid(valid2), .err_pulse(err2), .err_digit(errdig2)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] lut [16];

  // Reference model state: the current run of identical non-blank strobed samples.
  int          m_run = 0;
  logic [1:0]  m_d = 2'd0;
  logic [6:0]  m_s = 7'd0;
  logic [3:0]  m_slot [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0]  m_mask = 4'd0;
  logic [15:0] m_word = 16'd0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [1:0]  m_errdig = 2'd0;

  typedef struct {
    logic        stb;
    logic [1:0]  dig;
    logic [6:0]  seg;
    logic        ev;
    logic [15:0] ew;
    logic        ee;
    logic [1:0]  ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic stb, input logic [1:0] d,
                            input logic [6:0] s);
    int nib;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_run = 0; m_mask = 4'd0; m_word = 16'd0; m_errdig = 2'd0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'd0;
      return;
    end
    if (!stb || s == 7'h7f) return;
    if (m_run > 0 && d == m_d && s == m_s) m_run++;
    else begin
      m_d = d; m_s = s; m_run = 1;
    end
    if (m_run != StableN) return;
    nib = -1;
    for (int i = 0; i < 16; i++) if (lut[i] == s) nib = i;
    if (nib >= 0) begin
      m_slot[d] = nib[3:0];
      m_mask[d] = 1'b1;
      if (&m_mask) begin
        m_word  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_valid = 1'b1;
        m_mask  = 4'd0;
      end
    end else begin
      m_mask[d] = 1'b0;
      m_err     = 1'b1;
      m_errdig  = d;
    end
  endtask

  task automatic step(input logic rst, input logic stb, input logic [1:0] d, input logic [6:0] s);
    reset = rst; seg_strobe = stb; dig_sel = d; seg_in = s;
    @(posedge clk);
    model_edge(rst, stb, d, s);
    #1;
    chk("model_valid", 16'(word_valid), 16'(m_valid));
    chk("model_word", word_out, m_word);
    chk("model_err", 16'(err_pulse), 16'(m_err));
    chk("model_errdig", 16'(err_digit), 16'(m_errdig));
    chk("exclusive", 16'(word_valid & err_pulse), 16'd0);
  endtask

  task automatic capture(input logic [1:0] d, input logic [6:0] s);
    for (int i = 0; i < StableN; i++) step(1'b0, 1'b1, d, s);
  endtask

  initial begin
    logic [6:0] pats [4];
    logic       stb, rst;
    logic [1:0] pd;
    logic [6:0] ps;
    int         c;

    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    // Digit 0..3 showing 4,3,2,1 -> 16'h1234, then an invalid pattern on digit 2.
    pats = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        tbl.push_back('{1'b1, 2'(k), pats[k], (k == 3 && r == 3),
                        (k == 3 && r == 3) ? 16'h1234 : 16'h0000, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 7'h40, 1'b0, 16'h1234, 1'b0, 2'd0});
    for (int r = 0; r < 4; r++)
      tbl.push_back('{1'b1, 2'd2, 7'h55, 1'b0, 16'h1234, (r == 3), (r == 3) ? 2'd2 : 2'd0});
    tbl.push_back('{1'b0, 2'd0, 7'h40, 1'b0, 16'h1234, 1'b0, 2'd2});

    // Single-cycle acceptance instance, run while the main instance sits in reset.
    reset = 1'b1; seg_strobe = 1'b0; dig_sel = 2'd0; seg_in = 7'h7f;
    reset2 = 1'b1; strobe2 = 1'b0; dig2 = 2'd0; seg2 = 7'h7f;
    @(posedge clk); #1;
    chk("s1_reset_word", word2, 16'h0000);
    chk("s1_reset_valid", 16'(valid2), 16'd0);
    reset2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      strobe2 = 1'b1; dig2 = 2'(k); seg2 = 7'h0e;
      @(posedge clk); #1;
      chk("s1_valid", 16'(valid2), 16'(k == 3));
      chk("s1_err", 16'(err2), 16'd0);
    end
    chk("s1_word", word2, 16'hffff);
    strobe2 = 1'b0;
    @(posedge clk); #1;
    chk("s1_valid_drop", 16'(valid2), 16'd0);

    step(1'b1, 1'b1, 2'd0, 7'h40);
    step(1'b1, 1'b0, 2'd0, 7'h40);
    chk("reset_word", word_out, 16'h0000);
    chk("reset_errdig", 16'(err_digit), 16'd0);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].stb, tbl[i].dig, tbl[i].seg);
      chk("tbl_valid", 16'(word_valid), 16'(tbl[i].ev));
      chk("tbl_word", word_out, tbl[i].ew);
      chk("tbl_err", 16'(err_pulse), 16'(tbl[i].ee));
      chk("tbl_errdig", 16'(err_digit), 16'(tbl[i].ed));
    end

    // An error on a captured slot clears it, so the word cannot complete without it.
    capture(2'd2, 7'h24);
    capture(2'd2, 7'h55);
    capture(2'd0, 7'h79);
    capture(2'd1, 7'h24);
    capture(2'd3, 7'h30);
    chk("errmask_novalid", 16'(word_valid), 16'd0);
    capture(2'd2, 7'h40);
    chk("errmask_valid", 16'(word_valid), 16'd1);
    chk("errmask_word", word_out, 16'h3021);

    // Idle cycles and blanks between identical strobes neither reset nor advance the run.
    step(1'b0, 1'b1, 2'd0, 7'h08);
    step(1'b0, 1'b0, 2'd0, 7'h08);
    step(1'b0, 1'b1, 2'd1, 7'h7f);
    step(1'b0, 1'b1, 2'd0, 7'h08);
    step(1'b0, 1'b0, 2'd3, 7'h19);
    step(1'b0, 1'b1, 2'd0, 7'h08);
    step(1'b0, 1'b1, 2'd2, 7'h7f);
    step(1'b0, 1'b1, 2'd0, 7'h08);
    capture(2'd1, 7'h40);
    capture(2'd2, 7'h40);
    capture(2'd3, 7'h40);
    chk("blank_valid", 16'(word_valid), 16'd1);
    chk("blank_word", word_out, 16'h000a);

    // Reset discards a partial word.
    capture(2'd0, 7'h12);
    capture(2'd1, 7'h02);
    capture(2'd2, 7'h78);
    step(1'b1, 1'b1, 2'd0, 7'h12);
    chk("rst_word", word_out, 16'h0000);
    capture(2'd3, 7'h10);
    chk("rst_partial_novalid", 16'(word_valid), 16'd0);
    capture(2'd0, 7'h08);
    capture(2'd1, 7'h03);
    capture(2'd2, 7'h46);
    chk("rst_new_valid", 16'(word_valid), 16'd1);
    chk("rst_new_word", word_out, 16'h9cba);

    // Three strobes of 6 then a settled 8: only 8 lands in slot 1.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 7'h02);
    capture(2'd1, 7'h00);
    capture(2'd0, 7'h40);
    capture(2'd2, 7'h40);
    capture(2'd3, 7'h40);
    chk("glitch_valid", 16'(word_valid), 16'd1);
    chk("glitch_word", word_out, 16'h0080);

    pd = 2'd0; ps = 7'h40;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      stb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) >= 7) begin
        pd = 2'($urandom_range(0, 3));
        c  = $urandom_range(0, 9);
        if (c < 6) ps = lut[$urandom_range(0, 15)];
        else if (c < 8) ps = 7'h7f;
        else ps = 7'($urandom);
      end
      step(rst, stb, pd, ps);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: the number of consecutive identical strobed samples required before a digit is accepted.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have port seg_in, input, 7 bits: active-low segment bus, bit order gfedcba.
REQ-005 The module SHALL have port dig_sel, input, 2 bits: index of the digit currently driven on seg_in; 0 = least significant nibble.
REQ-006 The module SHALL have port seg_strobe, input, 1 bit: seg_in and dig_sel are valid this cycle.
REQ-007 The module SHALL have port word_out, output, 16 bits: last completed four-digit word, digit k in bits [4k+3:4k].
REQ-008 The module SHALL have port word_valid, output, 1 bit: one-cycle pulse when word_out updates.
REQ-009 The module SHALL have port err_pulse, output, 1 bit: one-cycle pulse when an undecodable stable pattern is accepted.
REQ-010 The module SHALL have port err_digit, output, 2 bits: dig_sel of the most recent error; holds between errors.

Function
REQ-011 The decode table SHALL be (hex: gfedcba) 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000 A:0001000 B:0000011 C:1000110 D:0100001 E:0000110 F:0001110.
REQ-012 Pattern 1111111 (blank) SHALL be ignored: no commit, no error, no effect on the held sample or the counter.
REQ-013 Any other pattern not in REQ-011 SHALL be invalid.
REQ-014 The block SHALL hold the sample {dig_sel, seg_in}, a 4-bit stable counter, a 4-bit captured mask, a 16-bit assembly register and state IDLE, STABILIZE or LOCKED.
REQ-015 Cycles with seg_strobe=0 SHALL change no state; the counter holds and is not reset.
REQ-016 In IDLE, a non-blank strobed sample SHALL be loaded with counter=1, entering STABILIZE; if STABLE_CYCLES=1 it SHALL be committed at the same edge and the state SHALL go to LOCKED.
REQ-017 In STABILIZE, a strobed sample equal to the held sample SHALL increment the counter; on reaching STABLE_CYCLES it SHALL commit and go to LOCKED.
REQ-018 In STABILIZE or LOCKED, a differing non-blank strobed sample SHALL reload the held sample with counter=1 and go to STABILIZE, committing immediately if STABLE_CYCLES=1.
REQ-019 In LOCKED, equal samples SHALL cause no further commits; the counter saturates.
REQ-020 A commit of a valid pattern SHALL write the nibble to slot dig_sel and set its mask bit, overwriting any earlier value in that slot.
REQ-021 A commit of an invalid pattern SHALL clear that slot's mask bit, pulse err_pulse and load err_digit, all registered at the commit edge.
REQ-022 When a commit sets the last missing mask bit, word_out SHALL load the assembled word including the new nibble, word_valid SHALL pulse, and the mask SHALL clear, all at the commit edge.
REQ-023 Latency: word_valid SHALL be high in the cycle after the edge sampling the STABLE_CYCLES-th identical strobe of the completing digit.
REQ-024 word_valid and err_pulse SHALL never be high for more than one consecutive cycle per commit, and SHALL be mutually exclusive.

Reset
REQ-025 While reset=1 at a clock edge, the state SHALL be IDLE and the counter, mask, assembly register, word_out, word_valid, err_pulse and err_digit SHALL all be 0.
REQ-026 Reset SHALL override any simultaneous strobe; a partially assembled word SHALL be discarded.

Verification
REQ-027 Default parameter: drive digits 0..3 with patterns for 4,3,2,1, each strobed 4 consecutive cycles -> one word_valid pulse, word_out=16'h1234, err_pulse never set.
REQ-028 Strobe digit 1 with 0000010 three times, then 0000000 four times -> slot 1 = 8, with no commit of 6.
REQ-029 Strobe digit 2 with 1010101 four times -> err_pulse for 1 cycle, err_digit=2, mask bit 2 clear.
REQ-030 Interleave seg_strobe=0 cycles and blank (1111111) strobes between four identical strobes of digit 0 = 0001000 -> slot 0 = A commits on the 4th valid strobe.
REQ-031 Capture digits 0..2, assert reset for 1 cycle, then capture only digit 3 -> no word_valid; after further capturing digits 0..2 -> word_valid with those new values.
REQ-032 STABLE_CYCLES=1: four single strobes of F on digits 0..3 -> word_valid the cycle after the 4th strobe, word_out=16'hFFFF.
